// File: rtl/fsm_job_scheduler.sv
// Round-robin scheduler sharing one job engine among N_REQ requesters,
// with a per-job RUN watchdog that aborts a hung job through the engine fault input.
module fsm_job_scheduler #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned STATE_W   = 3,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ack,
   output logic [N_REQ-1:0]           job_done,
   output logic [N_REQ-1:0]           job_err,
   output logic                       grant_vld,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   input  logic [TIMEOUT_W-1:0]       timeout_cyc,
   output logic                       res_start,
   output logic                       res_fault,
   input  logic                       res_busy,
   input  logic                       res_error,
   input  logic [STATE_W-1:0]         res_state,
   output logic [7:0]                 fault_cnt
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      RUN,
      RELEASE,
      ABORT,
      RECOVER
   } state_t;

   state_t               state;
   logic [ID_W-1:0]      owner;
   logic [ID_W-1:0]      rr_ptr;
   logic [ID_W-1:0]      winner;
   logic [N_REQ-1:0]     owner_oh;
   logic [TIMEOUT_W-1:0] wd_cnt;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int unsigned     ofs);
      int unsigned s;
      s = (32'(base) + ofs) % N_REQ;
      return ID_W'(s);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // First requester at or above rr_ptr (with wrap); the lowest offset is assigned last and wins
   always_comb begin
      winner = rr_ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[wrap_add(rr_ptr, unsigned'(k))]) winner = wrap_add(rr_ptr, unsigned'(k));
      end
   end

   assign owner_oh = N_REQ'(1) << owner;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         wd_cnt    <= '0;
         req_ack   <= '0;
         job_done  <= '0;
         job_err   <= '0;
         grant_vld <= 1'b0;
         grant_id  <= '0;
         res_start <= 1'b0;
         res_fault <= 1'b0;
         fault_cnt <= '0;
      end else begin
         req_ack  <= '0;
         job_done <= '0;
         job_err  <= '0;
         case (state)
            IDLE: begin
               if (|req_valid && res_state == '0) begin
                  state     <= LAUNCH;
                  owner     <= winner;
                  grant_id  <= winner;
                  grant_vld <= 1'b1;
                  req_ack   <= N_REQ'(1) << winner;
                  res_start <= 1'b1;
               end
            end
            LAUNCH: begin
               if (res_error) begin
                  state     <= RECOVER;
                  res_start <= 1'b0;
                  job_err   <= owner_oh;
                  fault_cnt <= sat_inc(fault_cnt);
               end else if (res_busy) begin
                  state  <= RUN;
                  wd_cnt <= TIMEOUT_W'(1);
               end
            end
            // Error beats completion, completion beats the watchdog
            RUN: begin
               if (res_error) begin
                  state     <= RECOVER;
                  res_start <= 1'b0;
                  job_err   <= owner_oh;
                  fault_cnt <= sat_inc(fault_cnt);
               end else if (!res_busy) begin
                  state     <= RELEASE;
                  res_start <= 1'b0;
                  job_done  <= owner_oh;
               end else if (timeout_cyc != '0 && wd_cnt == timeout_cyc) begin
                  state     <= ABORT;
                  res_start <= 1'b0;
                  res_fault <= 1'b1;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + TIMEOUT_W'(1);
               end
            end
            ABORT: begin
               if (res_error) begin
                  state     <= RECOVER;
                  res_fault <= 1'b0;
                  job_err   <= owner_oh;
                  fault_cnt <= sat_inc(fault_cnt);
               end
            end
            RELEASE, RECOVER: begin
               if (res_state == '0) begin
                  state     <= IDLE;
                  grant_vld <= 1'b0;
                  grant_id  <= '0;
                  rr_ptr    <= wrap_add(owner, 1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_job_scheduler.sv
// Randomized bench: a job-level timing model predicts every output cycle by cycle
// from the arbitration rule and the engine behaviour the bench itself plays out.
module tb_fsm_job_scheduler;

   localparam int unsigned N_REQ     = 4;
   localparam int unsigned STATE_W   = 3;
   localparam int unsigned TIMEOUT_W = 8;
   localparam int MAX_CYC = 9000;
   localparam int MID_CYC = 7000;
   localparam int SAT_LO  = 2500;
   localparam int SAT_HI  = 4500;
   localparam int BIG     = 1000000;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_REQ-1:0]     req_valid, req_ack, job_done, job_err;
   logic                 grant_vld;
   logic [1:0]           grant_id;
   logic [TIMEOUT_W-1:0] timeout_cyc;
   logic                 res_start, res_fault, res_busy, res_error;
   logic [STATE_W-1:0]   res_state;
   logic [7:0]           fault_cnt;

   always #5 clk = ~clk;

   fsm_job_scheduler #(.N_REQ(N_REQ), .STATE_W(STATE_W), .TIMEOUT_W(TIMEOUT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ack(req_ack),
      .job_done(job_done), .job_err(job_err), .grant_vld(grant_vld), .grant_id(grant_id),
      .timeout_cyc(timeout_cyc), .res_start(res_start), .res_fault(res_fault),
      .res_busy(res_busy), .res_error(res_error), .res_state(res_state), .fault_cnt(fault_cnt)
   );

   int n_vec = 0, n_mis = 0, cyc = 0;
   logic [N_REQ-1:0] req;
   int rr, fcnt;
   // Current job: kind 0 done, 1 run error, 2 watchdog abort, 3 launch error
   bit j_vld;
   int j_own, j_kind, j_a, j_rs, j_se, j_fs, j_o, j_i, j_bs, j_be, j_es;
   logic [STATE_W-1:0] j_nz;
   bit in_reset, first_rst, mid_done;
   int rst_cnt, quiet_until;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_cycle();
      bit act;
      logic [N_REQ-1:0] oh;
      act = j_vld && cyc >= j_a && cyc <= j_i - 1;
      oh  = j_vld ? N_REQ'(1) << j_own : '0;
      if (j_vld && j_kind != 0 && cyc == j_o && fcnt < 255) fcnt++;
      chk("req_ack",  32'(req_ack),  (j_vld && cyc == j_a) ? 32'(oh) : 32'd0);
      chk("job_done", 32'(job_done), (j_vld && j_kind == 0 && cyc == j_o) ? 32'(oh) : 32'd0);
      chk("job_err",  32'(job_err),  (j_vld && j_kind != 0 && cyc == j_o) ? 32'(oh) : 32'd0);
      chk("grant_vld", 32'(grant_vld), 32'(act));
      if (act) chk("grant_id", 32'(grant_id), 32'(j_own));
      chk("res_start", 32'(res_start), 32'(j_vld && cyc >= j_a && cyc <= j_se));
      chk("res_fault", 32'(res_fault), 32'(j_vld && j_kind == 2 && cyc >= j_fs && cyc < j_o));
      chk("fault_cnt", 32'(fault_cnt), 32'(fcnt));
   endtask

   task automatic check_reset_zero();
      chk("rst_req_ack",   32'(req_ack),   32'd0);
      chk("rst_job_done",  32'(job_done),  32'd0);
      chk("rst_job_err",   32'(job_err),   32'd0);
      chk("rst_grant_vld", 32'(grant_vld), 32'd0);
      chk("rst_grant_id",  32'(grant_id),  32'd0);
      chk("rst_res_start", 32'(res_start), 32'd0);
      chk("rst_res_fault", 32'(res_fault), 32'd0);
      chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
   endtask

   task automatic random_inputs();
      req_valid   = N_REQ'($urandom);
      timeout_cyc = TIMEOUT_W'($urandom);
      res_busy    = 1'($urandom);
      res_error   = 1'($urandom);
      res_state   = STATE_W'($urandom);
   endtask

   // Plan the next job and derive its whole output timeline
   task automatic new_job();
      int w, d, l, e, t, f, r, ke, kl, kt;
      bit hang, has_err, lerr;
      w = -1;
      for (int k = 0; k < int'(N_REQ); k++) begin
         int idx;
         idx = (rr + k) % int'(N_REQ);
         if (w < 0 && req[idx]) w = idx;
      end
      rr    = (w + 1) % int'(N_REQ);
      j_vld = 1'b1;
      j_own = w;
      j_a   = cyc + 1;
      case ($urandom_range(0, 3))
         0:       t = 0;
         1:       t = 8;
         default: t = int'($urandom_range(1, 12));
      endcase
      d = int'($urandom_range(1, 3));
      l = int'($urandom_range(1, 12));
      e = int'($urandom_range(1, 12));
      f = int'($urandom_range(1, 4));
      r = int'($urandom_range(1, 4));
      has_err = ($urandom_range(0, 3) == 0);
      hang    = (t != 0) && ($urandom_range(0, 4) == 0);
      lerr    = ($urandom_range(0, 19) == 0);
      if (t != 0 && $urandom_range(0, 4) == 0) l = t;
      if (cyc >= SAT_LO && cyc < SAT_HI) begin
         lerr = 1'b1;
         r    = 1;
      end
      j_nz = STATE_W'($urandom_range(1, 7));
      j_fs = BIG;
      if (lerr) begin
         j_kind = 3;
         j_rs   = j_a;
         j_o    = j_a + 1;
         j_se   = j_a;
         j_bs   = BIG;
         j_es   = j_a;
      end else begin
         j_rs = j_a + d;
         j_bs = j_rs - 1;
         ke = has_err ? e : BIG;
         kl = hang ? BIG : l;
         kt = (t != 0) ? t : BIG;
         if (ke <= kl && ke <= kt) begin
            j_kind = 1;
            j_o    = j_rs + e;
            j_se   = j_o - 1;
            j_es   = j_rs + e - 1;
         end else if (kl <= kt) begin
            j_kind = 0;
            j_o    = j_rs + l;
            j_se   = j_o - 1;
            j_es   = BIG;
         end else begin
            j_kind = 2;
            j_fs   = j_rs + t;
            j_o    = j_rs + t + f;
            j_se   = j_rs + t - 1;
            j_es   = j_o - 1;
         end
      end
      j_i  = j_o + r;
      j_be = (j_kind == 0) ? j_rs + l - 2 : j_i - 2;
      timeout_cyc = TIMEOUT_W'(t);
   endtask

   // Engine inputs for the coming edge, following the current job's plan
   task automatic drive_engine();
      if (j_vld && cyc >= j_a) begin
         res_busy  = (cyc >= j_bs && cyc <= j_be);
         res_error = (cyc >= j_es && cyc <= j_i - 2);
         res_state = (cyc <= j_i - 2) ? j_nz : '0;
      end else begin
         res_busy  = 1'b0;
         res_error = 1'b0;
         res_state = '0;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_reset    = 1'b1;
      first_rst   = 1'b1;
      mid_done    = 1'b0;
      rst_cnt     = 0;
      quiet_until = 0;
      req         = '0;
      rr          = 0;
      fcnt        = 0;
      j_vld       = 1'b0;
      random_inputs();
      for (int c = 0; c < MAX_CYC; c++) begin
         @(negedge clk);
         cyc = c;
         if (in_reset) begin
            check_reset_zero();
            rst_cnt++;
            if (rst_cnt == 3) begin
               rst_n    = 1'b1;
               in_reset = 1'b0;
               j_vld    = 1'b0;
               rr       = 0;
               fcnt     = 0;
               if (first_rst) begin
                  first_rst   = 1'b0;
                  req         = '0;
                  quiet_until = cyc + 8;
               end
               req_valid   = req;
               timeout_cyc = '0;
               if (req != '0) new_job();
               drive_engine();
            end else begin
               random_inputs();
            end
         end else begin
            check_cycle();
            if (!mid_done && cyc >= MID_CYC && j_vld && j_kind != 3 &&
                cyc >= j_rs && cyc <= j_se) begin
               mid_done = 1'b1;
               in_reset = 1'b1;
               rst_cnt  = 0;
               rst_n    = 1'b0;
               random_inputs();
            end else begin
               if (j_vld && cyc == j_a) req[j_own] = 1'b0;
               if (cyc >= quiet_until) begin
                  for (int k = 0; k < int'(N_REQ); k++) begin
                     if (!(j_vld && cyc == j_a && k == j_own) && !req[k]) begin
                        if ((cyc >= SAT_LO && cyc < SAT_HI) || $urandom_range(0, 2) == 0)
                           req[k] = 1'b1;
                     end
                  end
               end
               req_valid = req;
               if ((!j_vld || cyc >= j_i) && req != '0) new_job();
               drive_engine();
            end
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
